// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: compares the actual outcome against the IF prediction,
// raises a registered redirect on mispredict, squashes the wrong-path shadow and queues BTB training.
module branch_resolve_unit #(
    parameter int XLEN          = 32,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_is_compressed,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_target,
    output logic            o_squash,
    output logic            o_btb_upd_valid,
    input  logic            i_btb_upd_ready,
    output logic [XLEN-1:0] o_btb_upd_pc,
    output logic [XLEN-1:0] o_btb_upd_target,
    output logic            o_btb_upd_taken,
    output logic [31:0]     o_mispredict_count,
    output logic [15:0]     o_btb_drop_count
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
    } btb_ent_t;

    localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_CYCLES);

    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_target_q, redirect_target_d;
    logic [2:0]      shadow_q, shadow_d;
    logic [31:0]     mispredict_count_q, mispredict_count_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic [1:0]      btb_cnt_q, btb_cnt_d;
    btb_ent_t        ent_q [2];
    btb_ent_t        ent_d [2];

    logic            accepted, cond_taken, act_taken, mispredict, push, pop;
    logic [XLEN-1:0] jalr_sum, act_target, fall_through, redir_target;
    btb_ent_t        new_ent;

    assign o_squash = (shadow_q != 3'd0);

    always_comb begin
        accepted = i_valid && !i_stall && !i_flush && !o_squash
                   && (i_is_branch || i_is_jal || i_is_jalr);
        case (i_funct3)
            3'b000:  cond_taken = (i_rs1 == i_rs2);
            3'b001:  cond_taken = (i_rs1 != i_rs2);
            3'b100:  cond_taken = ($signed(i_rs1) <  $signed(i_rs2));
            3'b101:  cond_taken = ($signed(i_rs1) >= $signed(i_rs2));
            3'b110:  cond_taken = (i_rs1 <  i_rs2);
            3'b111:  cond_taken = (i_rs1 >= i_rs2);
            default: cond_taken = 1'b0;
        endcase
        act_taken    = i_is_jal || i_is_jalr || (i_is_branch && cond_taken);
        jalr_sum     = i_rs1 + i_imm;
        act_target   = i_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_pc + i_imm);
        fall_through = i_pc + (i_is_compressed ? XLEN'(2) : XLEN'(4));
        mispredict   = act_taken ? (!i_pred_taken || (i_pred_target != act_target))
                                 : i_pred_taken;
        redir_target = act_taken ? act_target : fall_through;
    end

    always_comb begin
        redirect_d         = redirect_q;
        redirect_target_d  = redirect_target_q;
        shadow_d           = shadow_q;
        mispredict_count_d = mispredict_count_q;
        if (i_flush) begin
            redirect_d = 1'b0;
            shadow_d   = 3'd0;
        end else if (accepted && mispredict) begin
            redirect_d         = 1'b1;
            redirect_target_d  = redir_target;
            shadow_d           = SHADOW_INIT;
            mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
            // Redirect is only retired once the PC controller saw it unstalled.
            if (redirect_q && !i_stall)
                redirect_d = 1'b0;
            if (i_valid && !i_stall && o_squash)
                shadow_d = shadow_q - 3'd1;
        end
    end

    always_comb begin
        push          = accepted && (act_taken || i_pred_taken);
        pop           = (btb_cnt_q != 2'd0) && i_btb_upd_ready;
        new_ent       = '{pc: i_pc, target: redir_target, taken: act_taken};
        ent_d         = ent_q;
        btb_cnt_d     = btb_cnt_q;
        drop_count_d  = drop_count_q;
        case ({push, pop})
            2'b11: begin
                if (btb_cnt_q == 2'd1) begin
                    ent_d[0] = new_ent;
                end else begin
                    ent_d[0] = ent_q[1];
                    ent_d[1] = new_ent;
                end
            end
            2'b01: begin
                ent_d[0]  = ent_q[1];
                btb_cnt_d = btb_cnt_q - 2'd1;
            end
            2'b10: begin
                if (btb_cnt_q == 2'd2) begin
                    if (drop_count_q != 16'hFFFF)
                        drop_count_d = drop_count_q + 16'd1;
                end else begin
                    ent_d[btb_cnt_q[0]] = new_ent;
                    btb_cnt_d           = btb_cnt_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            redirect_q         <= 1'b0;
            redirect_target_q  <= '0;
            shadow_q           <= 3'd0;
            mispredict_count_q <= 32'd0;
            drop_count_q       <= 16'd0;
            btb_cnt_q          <= 2'd0;
            ent_q[0]           <= '0;
            ent_q[1]           <= '0;
        end else begin
            redirect_q         <= redirect_d;
            redirect_target_q  <= redirect_target_d;
            shadow_q           <= shadow_d;
            mispredict_count_q <= mispredict_count_d;
            drop_count_q       <= drop_count_d;
            btb_cnt_q          <= btb_cnt_d;
            ent_q[0]           <= ent_d[0];
            ent_q[1]           <= ent_d[1];
        end
    end

    // Payload reads as zero whenever the queue is empty.
    assign o_btb_upd_valid    = (btb_cnt_q != 2'd0);
    assign o_btb_upd_pc       = o_btb_upd_valid ? ent_q[0].pc     : '0;
    assign o_btb_upd_target   = o_btb_upd_valid ? ent_q[0].target : '0;
    assign o_btb_upd_taken    = o_btb_upd_valid && ent_q[0].taken;
    assign o_redirect         = redirect_q;
    assign o_redirect_target  = redirect_target_q;
    assign o_mispredict_count = mispredict_count_q;
    assign o_btb_drop_count   = drop_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int SC = 2;

    logic        i_clk = 1'b0;
    logic        i_reset, i_stall, i_flush, i_valid;
    logic        i_is_branch, i_is_jal, i_is_jalr, i_is_compressed, i_pred_taken;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1, i_rs2, i_imm, i_pc, i_pred_target;
    logic        i_btb_upd_ready;
    logic        o_redirect, o_squash, o_btb_upd_valid, o_btb_upd_taken;
    logic [31:0] o_redirect_target, o_btb_upd_pc, o_btb_upd_target, o_mispredict_count;
    logic [15:0] o_btb_drop_count;

    branch_resolve_unit #(.XLEN(32), .SHADOW_CYCLES(SC)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_is_branch(i_is_branch), .i_is_jal(i_is_jal),
        .i_is_jalr(i_is_jalr), .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_imm(i_imm), .i_pc(i_pc), .i_is_compressed(i_is_compressed),
        .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
        .o_redirect(o_redirect), .o_redirect_target(o_redirect_target),
        .o_squash(o_squash), .o_btb_upd_valid(o_btb_upd_valid),
        .i_btb_upd_ready(i_btb_upd_ready), .o_btb_upd_pc(o_btb_upd_pc),
        .o_btb_upd_target(o_btb_upd_target), .o_btb_upd_taken(o_btb_upd_taken),
        .o_mispredict_count(o_mispredict_count), .o_btb_drop_count(o_btb_drop_count)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural outcome of one instruction.
    function automatic void resolve(input logic br, input logic jal, input logic jalr,
                                    input logic [2:0] f3, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [31:0] imm,
                                    input logic [31:0] pc, input logic c,
                                    output bit tk, output logic [31:0] tgt,
                                    output logic [31:0] ft);
        int s1, s2;
        s1 = rs1;
        s2 = rs2;
        case (f3)
            3'd0: tk = (rs1 == rs2);
            3'd1: tk = (rs1 != rs2);
            3'd4: tk = (s1 < s2);
            3'd5: tk = (s1 >= s2);
            3'd6: tk = (rs1 < rs2);
            3'd7: tk = (rs1 >= rs2);
            default: tk = 1'b0;
        endcase
        tk  = jal || jalr || (br && tk);
        tgt = jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        ft  = pc + (c ? 32'd2 : 32'd4);
    endfunction

    // Reference model state.
    bit          m_redir;
    logic [31:0] m_tgt;
    int          m_shadow;
    logic [31:0] m_mcnt;
    int          m_dcnt;
    logic [31:0] m_qpc[$];
    logic [31:0] m_qtg[$];
    bit          m_qtk[$];

    always @(posedge i_clk) begin
        bit tk, acc, mis, pop, push;
        logic [31:0] tgt, ft;
        int sz;
        if (i_reset) begin
            m_redir = 0; m_tgt = 0; m_shadow = 0; m_mcnt = 0; m_dcnt = 0;
            m_qpc.delete(); m_qtg.delete(); m_qtk.delete();
        end else begin
            resolve(i_is_branch, i_is_jal, i_is_jalr, i_funct3, i_rs1, i_rs2, i_imm,
                    i_pc, i_is_compressed, tk, tgt, ft);
            acc  = i_valid && !i_stall && !i_flush && (m_shadow == 0)
                   && (i_is_branch || i_is_jal || i_is_jalr);
            mis  = tk ? (!i_pred_taken || i_pred_target != tgt) : i_pred_taken;
            sz   = m_qpc.size();
            pop  = (sz > 0) && i_btb_upd_ready;
            push = acc && (tk || i_pred_taken);
            if (pop) begin
                void'(m_qpc.pop_front()); void'(m_qtg.pop_front()); void'(m_qtk.pop_front());
            end
            if (push) begin
                if (sz == 2 && !pop) begin
                    if (m_dcnt < 65535) m_dcnt++;
                end else begin
                    m_qpc.push_back(i_pc); m_qtg.push_back(tk ? tgt : ft); m_qtk.push_back(tk);
                end
            end
            if (i_flush) begin
                m_redir = 0; m_shadow = 0;
            end else if (acc && mis) begin
                m_redir = 1; m_tgt = tk ? tgt : ft; m_shadow = SC; m_mcnt = m_mcnt + 1;
            end else begin
                if (!i_stall) m_redir = 0;
                if (i_valid && !i_stall && m_shadow > 0) m_shadow--;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            bit qv;
            qv = (m_qpc.size() > 0);
            chk("redirect", {31'd0, o_redirect}, {31'd0, m_redir});
            chk("redirect_target", o_redirect_target, m_tgt);
            chk("squash", {31'd0, o_squash}, {31'd0, m_shadow != 0});
            chk("mispredict_count", o_mispredict_count, m_mcnt);
            chk("drop_count", {16'd0, o_btb_drop_count}, m_dcnt[31:0]);
            chk("btb_valid", {31'd0, o_btb_upd_valid}, {31'd0, qv});
            chk("btb_pc", o_btb_upd_pc, qv ? m_qpc[0] : 32'd0);
            chk("btb_target", o_btb_upd_target, qv ? m_qtg[0] : 32'd0);
            chk("btb_taken", {31'd0, o_btb_upd_taken}, {31'd0, qv && m_qtk[0]});
        end
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic br, input logic jal, input logic jalr,
                           input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc, input logic c,
                           input logic pt, input logic [31:0] ptg);
        i_valid = v; i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr; i_funct3 = f3;
        i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc; i_is_compressed = c;
        i_pred_taken = pt; i_pred_target = ptg;
    endtask

    task automatic idle();
        set_ins(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic bubble();
        set_ins(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        i_reset = 1; i_stall = 0; i_flush = 0; i_btb_upd_ready = 1;
        idle();
        repeat (2) @(posedge i_clk);
        #1;
        chk_en  = 1'b1;
        i_reset = 0;
        chk("rst_redirect", {31'd0, o_redirect}, 32'd0);
        chk("rst_mcnt", o_mispredict_count, 32'd0);
        chk("rst_btb_valid", {31'd0, o_btb_upd_valid}, 32'd0);

        // BEQ taken, unpredicted.
        i_btb_upd_ready = 0;
        set_ins(1, 1, 0, 0, 3'b000, 5, 5, 32'h40, 32'h100, 0, 0, 0);
        cyc();
        chk("t1_redirect", {31'd0, o_redirect}, 32'd1);
        chk("t1_target", o_redirect_target, 32'h140);
        chk("t1_mcnt", o_mispredict_count, 32'd1);
        chk("t1_btb_pc", o_btb_upd_pc, 32'h100);
        chk("t1_btb_tgt", o_btb_upd_target, 32'h140);
        chk("t1_btb_tk", {31'd0, o_btb_upd_taken}, 32'd1);
        chk("t1_squash0", {31'd0, o_squash}, 32'd1);
        cyc();
        chk("t1_squash1", {31'd0, o_squash}, 32'd1);
        chk("t1_redir_fall", {31'd0, o_redirect}, 32'd0);
        cyc();
        chk("t1_squash_end", {31'd0, o_squash}, 32'd0);
        chk("t1_mcnt_held", o_mispredict_count, 32'd1);
        idle();
        i_btb_upd_ready = 1;
        cyc();
        chk("t1_drained", {31'd0, o_btb_upd_valid}, 32'd0);

        // BLT signed taken and correctly predicted, then BLTU not taken.
        i_btb_upd_ready = 0;
        set_ins(1, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1, 32'h100, 32'h200, 1, 1, 32'h300);
        cyc();
        chk("t2_no_redirect", {31'd0, o_redirect}, 32'd0);
        chk("t2_btb_pc", o_btb_upd_pc, 32'h200);
        chk("t2_btb_tgt", o_btb_upd_target, 32'h300);
        chk("t2_btb_tk", {31'd0, o_btb_upd_taken}, 32'd1);
        i_funct3 = 3'b110;
        cyc();
        chk("t2u_redirect", {31'd0, o_redirect}, 32'd1);
        chk("t2u_target", o_redirect_target, 32'h202);
        chk("t2u_mcnt", o_mispredict_count, 32'd2);
        bubble();
        i_btb_upd_ready = 1;
        cyc();
        chk("t2u_btb_pc", o_btb_upd_pc, 32'h200);
        chk("t2u_btb_tgt", o_btb_upd_target, 32'h202);
        chk("t2u_btb_tk", {31'd0, o_btb_upd_taken}, 32'd0);
        cyc();
        chk("t2_squash_end", {31'd0, o_squash}, 32'd0);
        idle();

        // JALR predicted correctly, then mispredicted and held by a 3-cycle stall.
        set_ins(1, 0, 0, 1, 3'd0, 32'h1001, 0, 32'd2, 32'h500, 0, 1, 32'h1002);
        cyc();
        chk("t3_no_redirect", {31'd0, o_redirect}, 32'd0);
        chk("t3_mcnt", o_mispredict_count, 32'd2);
        i_pred_target = 32'h1000;
        cyc();
        chk("t3_redirect", {31'd0, o_redirect}, 32'd1);
        chk("t3_target", o_redirect_target, 32'h1002);
        i_stall = 1;
        bubble();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_stall_hold", {31'd0, o_redirect}, 32'd1);
        end
        i_stall = 0;
        cyc();
        chk("t3_redirect_fall", {31'd0, o_redirect}, 32'd0);
        chk("t3_shadow_kept", {31'd0, o_squash}, 32'd1);
        cyc();
        chk("t3_squash_end", {31'd0, o_squash}, 32'd0);
        idle();
        cyc();

        // Three taken JALs into a stalled BTB port.
        i_btb_upd_ready = 0;
        for (int k = 0; k < 3; k++) begin
            set_ins(1, 0, 1, 0, 3'd0, 0, 0, 32'h10, 32'h400 + 4 * k, 0, 1, 32'h410 + 4 * k);
            cyc();
        end
        idle();
        chk("t4_drop", {16'd0, o_btb_drop_count}, 32'd1);
        chk("t4_head_pc", o_btb_upd_pc, 32'h400);
        i_btb_upd_ready = 1;
        cyc();
        chk("t4_second_pc", o_btb_upd_pc, 32'h404);
        chk("t4_second_tgt", o_btb_upd_target, 32'h414);
        cyc();
        chk("t4_empty", {31'd0, o_btb_upd_valid}, 32'd0);

        // Flush right after a mispredict.
        set_ins(1, 1, 0, 0, 3'b000, 5, 5, 32'h20, 32'h600, 0, 0, 0);
        cyc();
        chk("t5_redirect", {31'd0, o_redirect}, 32'd1);
        idle();
        i_flush = 1;
        cyc();
        i_flush = 0;
        chk("t5_flush_redirect", {31'd0, o_redirect}, 32'd0);
        chk("t5_flush_squash", {31'd0, o_squash}, 32'd0);

        // Reset in the middle of a shadow.
        set_ins(1, 1, 0, 0, 3'b001, 5, 6, 32'h20, 32'h700, 0, 0, 0);
        cyc();
        chk("t6_squash", {31'd0, o_squash}, 32'd1);
        idle();
        i_reset = 1;
        cyc();
        i_reset = 0;
        chk("t6_redirect", {31'd0, o_redirect}, 32'd0);
        chk("t6_target", o_redirect_target, 32'd0);
        chk("t6_squash", {31'd0, o_squash}, 32'd0);
        chk("t6_btb_valid", {31'd0, o_btb_upd_valid}, 32'd0);
        chk("t6_mcnt", o_mispredict_count, 32'd0);
        chk("t6_drop", {16'd0, o_btb_drop_count}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit tk;
            logic [31:0] tgt, ft;
            int cls;
            cls = $urandom_range(0, 3);
            set_ins($urandom_range(0, 9) < 8, cls == 0, cls == 1, cls == 2,
                    3'($urandom), $urandom_range(0, 7), 0, 32'($urandom_range(0, 255)) << 1,
                    32'($urandom_range(0, 4095)) << 1, 1'($urandom), 1'($urandom), 0);
            i_rs2 = ($urandom_range(0, 1) != 0) ? i_rs1 : 32'($urandom_range(0, 7)) - 32'd4;
            if ($urandom_range(0, 3) == 0) i_rs1 = $urandom;
            resolve(i_is_branch, i_is_jal, i_is_jalr, i_funct3, i_rs1, i_rs2, i_imm, i_pc,
                    i_is_compressed, tk, tgt, ft);
            i_pred_target   = ($urandom_range(0, 9) < 7) ? tgt : $urandom;
            i_stall         = ($urandom_range(0, 4) == 0);
            i_flush         = ($urandom_range(0, 19) == 0);
            i_btb_upd_ready = 1'($urandom);
            i_reset         = ($urandom_range(0, 399) == 0);
            cyc();
        end
        i_reset = 0; i_stall = 0; i_flush = 0;
        idle();
        cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
